// File: rtl/icache_controller.sv
// Direct-mapped, read-only instruction cache for the Fetch stage.
// Hits are served combinationally; a miss runs a blocking IDLE -> REFILL -> INSTALL refill.
module icache_controller #(
    parameter int S = 32,
    parameter int B = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic [31:0] InstrF,
    output logic        InstrMissF,
    output logic        InstrCacheRepActive,
    output logic        RepReq,
    output logic [31:0] RepBlockAddr,
    input  logic        RepValid,
    input  logic [31:0] RepWord
);
    localparam int WB = $clog2(B);
    localparam int OB = WB + 2;
    localparam int IB = $clog2(S);
    localparam int TB = 32 - IB - OB;

    // Handshake: RepReq stays high for the whole refill; each cycle with RepValid=1
    // while in REFILL transfers exactly one word, ascending from offset 0.
    typedef enum logic [1:0] {IDLE, REFILL, INSTALL} state_t;

    state_t        state_q, state_d;
    logic [S-1:0]  valid_q, valid_d;
    logic [TB-1:0] tag_q [S];
    logic [31:0]   data_q [S][B];
    logic [IB-1:0] ref_idx_q, ref_idx_d;
    logic [TB-1:0] ref_tag_q, ref_tag_d;
    logic [WB-1:0] wc_q, wc_d;
    logic          rep_req_q, rep_req_d;
    logic [31:0]   rep_addr_q, rep_addr_d;
    logic          rep_active_q, rep_active_d;
    logic          data_we, tag_we;

    logic [IB-1:0] idx;
    logic [TB-1:0] tg;
    logic [WB-1:0] wo;
    logic          hit;
    logic          pcf_unused;

    assign idx        = PCF[OB+IB-1:OB];
    assign tg         = PCF[31:OB+IB];
    assign wo         = PCF[OB-1:2];
    assign pcf_unused = ^PCF[1:0];

    assign hit                 = valid_q[idx] && (tag_q[idx] == tg);
    assign InstrF              = data_q[idx][wo];
    assign InstrMissF          = (state_q != IDLE) || !hit;
    assign RepReq              = rep_req_q;
    assign RepBlockAddr        = rep_addr_q;
    assign InstrCacheRepActive = rep_active_q;

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        ref_idx_d    = ref_idx_q;
        ref_tag_d    = ref_tag_q;
        wc_d         = wc_q;
        rep_req_d    = rep_req_q;
        rep_addr_d   = rep_addr_q;
        rep_active_d = 1'b0;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hit) begin
                    ref_idx_d    = idx;
                    ref_tag_d    = tg;
                    rep_addr_d   = {PCF[31:OB], {OB{1'b0}}};
                    wc_d         = '0;
                    // Invalidate up front so a half-written line can never hit.
                    valid_d[idx] = 1'b0;
                    rep_req_d    = 1'b1;
                    state_d      = REFILL;
                end
            end
            REFILL: begin
                if (RepValid) begin
                    data_we = 1'b1;
                    wc_d    = wc_q + WB'(1);
                    if (wc_q == WB'(B - 1)) begin
                        rep_req_d    = 1'b0;
                        rep_active_d = 1'b1;
                        state_d      = INSTALL;
                    end
                end
            end
            INSTALL: begin
                valid_d[ref_idx_q] = 1'b1;
                tag_we             = 1'b1;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            ref_idx_q    <= '0;
            ref_tag_q    <= '0;
            wc_q         <= '0;
            rep_req_q    <= 1'b0;
            rep_addr_q   <= '0;
            rep_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            ref_idx_q    <= ref_idx_d;
            ref_tag_q    <= ref_tag_d;
            wc_q         <= wc_d;
            rep_req_q    <= rep_req_d;
            rep_addr_q   <= rep_addr_d;
            rep_active_q <= rep_active_d;
        end
    end

    // Tag and data arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (data_we) data_q[ref_idx_q][wc_q] <= RepWord;
        if (tag_we)  tag_q[ref_idx_q]        <= ref_tag_q;
    end

endmodule
